// File: rtl/toggle_pulse_spacer.sv
// Source-domain event spacer ahead of a toggle synchronizer: counts incoming
// event requests and replays them as single-cycle pulses separated by MIN_GAP idle cycles.
module toggle_pulse_spacer #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned MIN_GAP = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             evt_in,
  input  logic             clr_ovf,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, FIRE, GAP} state_e;

  localparam logic [CNT_W-1:0] ONE     = 1;
  localparam logic [7:0]       GAP_LD  = 8'(MIN_GAP);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [7:0]       gap_q, gap_d;
  logic             pulse_q, pulse_d;
  logic             ovf_q, ovf_d;
  logic             inc, dec, drop;

  // Pending counter and sticky overflow; a drop only happens without a simultaneous FIRE
  always_comb begin
    inc  = evt_in;
    dec  = (state_q == FIRE);
    drop = inc & ~dec & (pend_q == '1);
    pend_d = pend_q;
    if (inc && !dec && !drop) begin
      pend_d = pend_q + ONE;
    end else if (dec && !inc) begin
      pend_d = pend_q - ONE;
    end
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      gap_q   <= '0;
      pulse_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      gap_q   <= gap_d;
      pulse_q <= pulse_d;
      ovf_q   <= ovf_d;
    end
  end

  // The end-of-gap decision looks at the post-edge count so a same-cycle event is not delayed
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (pend_q != '0) state_d = FIRE;
      end
      FIRE: begin
        state_d = GAP;
        gap_d   = GAP_LD;
      end
      GAP: begin
        gap_d = gap_q - 8'd1;
        if (gap_q == 8'd1) begin
          state_d = (pend_d != '0) ? FIRE : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gap_d   = '0;
      end
    endcase
  end

  always_comb begin
    pulse_d   = (state_d == FIRE);
    pulse_out = pulse_q;
    pending   = pend_q;
    overflow  = ovf_q;
    busy      = (state_q != IDLE) | (pend_q != '0);
  end

endmodule

// File: tb/tb_toggle_pulse_spacer.sv
// Scoreboarded bench for toggle_pulse_spacer: default build plus a MIN_GAP=1 build.
module tb_toggle_pulse_spacer;

  localparam int unsigned CW = 4;
  localparam int unsigned MG = 3;

  logic          clk = 1'b0;
  logic          reset_n, evt_in, clr_ovf, evt_in1, clr_ovf1;
  logic          pulse_out, busy, overflow;
  logic          pulse_out1, busy1, overflow1;
  logic [CW-1:0] pending, pending1;

  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned exp_q[$];
  int unsigned obs_q[$];
  int unsigned obs1_q[$];

  always #5 clk = ~clk;

  toggle_pulse_spacer #(.CNT_W(CW), .MIN_GAP(MG)) u_dut (
    .clk(clk), .reset_n(reset_n), .evt_in(evt_in), .clr_ovf(clr_ovf),
    .pulse_out(pulse_out), .pending(pending), .busy(busy), .overflow(overflow)
  );

  toggle_pulse_spacer #(.CNT_W(CW), .MIN_GAP(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .evt_in(evt_in1), .clr_ovf(clr_ovf1),
    .pulse_out(pulse_out1), .pending(pending1), .busy(busy1), .overflow(overflow1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Observed pulses tagged with the number of the edge that raised them
  always @(negedge clk) begin
    if (pulse_out)  obs_q.push_back(cyc);
    if (pulse_out1) obs1_q.push_back(cyc);
  end

  task automatic test_reset();
    reset_n = 1'b0; evt_in = 1'b0; clr_ovf = 1'b0; evt_in1 = 1'b0; clr_ovf1 = 1'b0;
    #2;
    n_vec++;
    if ({pulse_out, pending, busy, overflow, pulse_out1} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got p=%b pend=%0d busy=%b ovf=%b p1=%b, expected all 0",
               pulse_out, pending, busy, overflow, pulse_out1);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({pulse_out, pending, busy, overflow} !== '0) begin
      n_err++;
      $display("FAIL reset_release: got p=%b pend=%0d busy=%b ovf=%b, expected all 0",
               pulse_out, pending, busy, overflow);
    end
  endtask

  task automatic test_single();
    int unsigned base, e, o;
    base = cyc;
    obs_q.delete();
    for (int k = 1; k <= 12; k++) begin
      evt_in = (k == 1);
      if (k == 1) exp_q.push_back(base + 2);
      @(negedge clk);
      if (k == 1 || k == 2 || k == 3) begin
        n_vec++;
        if (pending !== ((k == 3) ? 4'd0 : 4'd1)) begin
          n_err++;
          $display("FAIL single_pending edge %0d: got %0d, expected %0d", k, pending, (k == 3) ? 0 : 1);
        end
      end
      if (k == 5 || k == 6) begin
        n_vec++;
        if (busy !== (k == 5)) begin
          n_err++;
          $display("FAIL single_busy edge %0d: got %b, expected %b", k, busy, (k == 5));
        end
      end
    end
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL single_overflow: got %b, expected 0", overflow);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++;
        $display("FAIL single_pulse: got none, expected at edge %0d", e - base);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL single_pulse: got edge %0d, expected edge %0d", o - base, e - base);
        end
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL single_extra: got %0d extra pulses, expected 0", obs_q.size());
    end
  endtask

  task automatic test_burst();
    int unsigned base, e, o;
    base = cyc;
    obs_q.delete();
    for (int k = 1; k <= 26; k++) begin
      evt_in = (k <= 5);
      if (k <= 5) exp_q.push_back(base + 2 + (MG + 1) * (k - 1));
      @(negedge clk);
      if (k == 5) begin
        n_vec++;
        if (pending !== 4'd4) begin
          n_err++;
          $display("FAIL burst_peak: got %0d, expected 4", pending);
        end
      end
    end
    n_vec++;
    if (pending !== 4'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL burst_drain: got pend=%0d busy=%b, expected pend=0 busy=0", pending, busy);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++;
        $display("FAIL burst_pulse: got none, expected at edge %0d", e - base);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL burst_pulse: got edge %0d, expected edge %0d", o - base, e - base);
        end
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL burst_extra: got %0d extra pulses, expected 0", obs_q.size());
    end
  endtask

  task automatic test_saturation();
    int unsigned base, e, o, j;
    base = cyc;
    j = 0;
    obs_q.delete();
    for (int k = 1; k <= 95; k++) begin
      evt_in = (k <= 24);
      if (k <= 24 && !(k == 21 || k == 22 || k == 24)) begin
        exp_q.push_back(base + 2 + (MG + 1) * j);
        j++;
      end
      @(negedge clk);
      if (k >= 20 && k <= 24) begin
        n_vec++;
        if (pending !== 4'd15 || overflow !== (k >= 21)) begin
          n_err++;
          $display("FAIL sat_edge%0d: got pend=%0d ovf=%b, expected pend=15 ovf=%b",
                   k, pending, overflow, (k >= 21));
        end
      end
    end
    n_vec++;
    if (pending !== 4'd0 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL sat_drain: got pend=%0d ovf=%b, expected pend=0 ovf=1", pending, overflow);
    end
    n_vec++;
    if (obs_q.size() != 21) begin
      n_err++;
      $display("FAIL sat_count: got %0d pulses, expected 21", obs_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++;
        $display("FAIL sat_pulse: got none, expected at edge %0d", e - base);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL sat_pulse: got edge %0d, expected edge %0d", o - base, e - base);
        end
      end
    end
  endtask

  task automatic test_overflow_clear();
    logic exp_ovf;
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear: got %b, expected 0", overflow);
    end
    // Refill: edge 22 clears during a drop, edge 23 clears with no drop, edge 24 drops again
    for (int k = 1; k <= 95; k++) begin
      evt_in  = (k <= 24);
      clr_ovf = (k == 22 || k == 23);
      @(negedge clk);
      if (k >= 20 && k <= 24) begin
        exp_ovf = (k >= 21) && (k != 23);
        n_vec++;
        if (overflow !== exp_ovf) begin
          n_err++;
          $display("FAIL ovf_edge%0d: got %b, expected %b", k, overflow, exp_ovf);
        end
      end
    end
    clr_ovf = 1'b0;
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    for (int k = 1; k <= 9; k++) begin
      evt_in = 1'b1;
      @(negedge clk);
    end
    evt_in = 1'b0;
    n_vec++;
    if (pending !== 4'd7 || busy !== 1'b1 || pulse_out !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_pre: got pend=%0d busy=%b p=%b, expected pend=7 busy=1 p=0",
               pending, busy, pulse_out);
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (pulse_out !== 1'b0 || pending !== 4'd0 || busy !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_async: got p=%b pend=%0d busy=%b ovf=%b, expected all 0",
               pulse_out, pending, busy, overflow);
    end
    @(negedge clk);
    reset_n = 1'b1;
    obs_q.delete();
    for (int k = 1; k <= 50; k++) @(negedge clk);
    n_vec++;
    if (obs_q.size() != 0 || pending !== 4'd0) begin
      n_err++;
      $display("FAIL rmid_quiet: got %0d pulses pend=%0d, expected 0 pulses pend=0",
               obs_q.size(), pending);
    end
  endtask

  task automatic test_min_gap1();
    int unsigned base, e, o;
    logic prev, exp_p;
    base = cyc;
    prev = 1'b0;
    obs1_q.delete();
    for (int k = 1; k <= 14; k++) begin
      evt_in1 = (k <= 4);
      if (k <= 4) exp_q.push_back(base + 2 + 2 * (k - 1));
      @(negedge clk);
      exp_p = (k >= 2) && (k <= 8) && (k % 2 == 0);
      n_vec++;
      if (pulse_out1 !== exp_p || (prev && pulse_out1)) begin
        n_err++;
        $display("FAIL mg1_wave edge %0d: got %b (prev %b), expected %b", k, pulse_out1, prev, exp_p);
      end
      prev = pulse_out1;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs1_q.size() == 0) begin
        n_err++;
        $display("FAIL mg1_pulse: got none, expected at edge %0d", e - base);
      end else begin
        o = obs1_q.pop_front();
        if (o !== e) begin
          n_err++;
          $display("FAIL mg1_pulse: got edge %0d, expected edge %0d", o - base, e - base);
        end
      end
    end
    n_vec++;
    if (obs1_q.size() != 0 || pending1 !== 4'd0) begin
      n_err++;
      $display("FAIL mg1_drain: got %0d extra pend=%0d, expected 0 extra pend=0",
               obs1_q.size(), pending1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_saturation();
    test_overflow_clear();
    test_reset_mid();
    test_min_gap1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
